// File: rtl/cnt_burst_arbiter_pkg.sv
// Shared types and constants for the burst arbiter in front of the dual-channel select counter.
package cnt_burst_arbiter_pkg;

    localparam int LEN_W_DEF   = 8;
    localparam int QUANTUM_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_SWITCH = 2'd2
    } arb_state_t;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage

// File: rtl/cnt_burst_arbiter_slot.sv
// One requester slot: captures a burst length over valid/ready, counts it down on dec,
// and pulses done one cycle after the count reaches zero (or after a zero-length accept).
module cnt_burst_arbiter_slot
    import cnt_burst_arbiter_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             req_valid,
    input  logic [LEN_W-1:0] req_len,
    output logic             req_ready,
    input  logic             dec,
    output logic             pending,
    output logic             done
);

    logic [LEN_W-1:0] remaining;
    logic             finish;
    logic             accept;

    assign req_ready = (remaining == '0);
    assign pending   = (remaining != '0);
    assign accept    = req_valid && req_ready;

    // finish marks the edge the burst emptied; done follows one cycle later so it lands after the last En
    always_ff @(posedge Clk) begin
        if (Reset) begin
            remaining <= '0;
            finish    <= 1'b0;
            done      <= 1'b0;
        end else begin
            done   <= finish;
            finish <= (accept && (req_len == '0)) || (dec && (remaining == LEN_W'(1)));
            if (accept) begin
                remaining <= req_len;
            end else if (dec && (remaining != '0)) begin
                remaining <= remaining - LEN_W'(1);
            end
        end
    end

endmodule

// File: rtl/cnt_burst_arbiter.sv
// Round-robin burst arbiter driving the select counter's Slt/En with a per-grant quantum.
// state  | meaning
// IDLE   | no En issued, waiting for a pending channel
// RUN    | En=1 this cycle for owner Slt
// SWITCH | one En=0 gap, Slt already points at the new owner
module cnt_burst_arbiter
    import cnt_burst_arbiter_pkg::*;
#(
    parameter int LEN_W   = LEN_W_DEF,
    parameter int QUANTUM = QUANTUM_DEF
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Req0_valid,
    input  logic [LEN_W-1:0] Req0_len,
    output logic             Req0_ready,
    input  logic             Req1_valid,
    input  logic [LEN_W-1:0] Req1_len,
    output logic             Req1_ready,
    output logic             Slt,
    output logic             En,
    output logic             Done0,
    output logic             Done1,
    output logic             Busy
);

    localparam int             Q_W   = $clog2(QUANTUM + 1);
    localparam logic [Q_W-1:0] Q_MAX = Q_W'(QUANTUM);

    arb_state_t     state_q, state_d;
    logic           rr_q, rr_d;
    logic [Q_W-1:0] qcnt_q, qcnt_d;
    logic           slt_d, en_d;
    logic           pend0, pend1, dec0, dec1;
    logic           own_pend, oth_pend;

    cnt_burst_arbiter_slot #(.LEN_W(LEN_W)) u_slot0 (
        .Clk(Clk), .Reset(Reset), .req_valid(Req0_valid), .req_len(Req0_len),
        .req_ready(Req0_ready), .dec(dec0), .pending(pend0), .done(Done0)
    );

    cnt_burst_arbiter_slot #(.LEN_W(LEN_W)) u_slot1 (
        .Clk(Clk), .Reset(Reset), .req_valid(Req1_valid), .req_len(Req1_len),
        .req_ready(Req1_ready), .dec(dec1), .pending(pend1), .done(Done1)
    );

    assign own_pend = Slt ? pend1 : pend0;
    assign oth_pend = Slt ? pend0 : pend1;
    assign Busy     = (state_q != ST_IDLE);

    // en_d issues the En for the coming cycle, so the owner is decremented on the same edge
    always_comb begin
        state_d = state_q;
        slt_d   = Slt;
        en_d    = 1'b0;
        rr_d    = rr_q;
        qcnt_d  = qcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pend0 || pend1) begin
                    state_d = ST_RUN;
                    slt_d   = (pend0 && pend1) ? ~rr_q : pend1;
                    rr_d    = slt_d;
                    en_d    = 1'b1;
                    qcnt_d  = Q_W'(1);
                end
            end
            ST_RUN: begin
                if (!own_pend || ((qcnt_q == Q_MAX) && oth_pend)) begin
                    qcnt_d = '0;
                    if (oth_pend) begin
                        state_d = ST_SWITCH;
                        slt_d   = ~Slt;
                        rr_d    = slt_d;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    en_d   = 1'b1;
                    qcnt_d = (qcnt_q == Q_MAX) ? Q_W'(1) : qcnt_q + Q_W'(1);
                end
            end
            ST_SWITCH: begin
                if (own_pend) begin
                    state_d = ST_RUN;
                    en_d    = 1'b1;
                    qcnt_d  = Q_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign dec0 = en_d && (slt_d == CH0);
    assign dec1 = en_d && (slt_d == CH1);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            Slt     <= CH0;
            En      <= 1'b0;
            rr_q    <= CH1;
            qcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            Slt     <= slt_d;
            En      <= en_d;
            rr_q    <= rr_d;
            qcnt_q  <= qcnt_d;
        end
    end

endmodule

// File: tb/tb_cnt_burst_arbiter.sv
// Directed bench for cnt_burst_arbiter: reset, single bursts, zero length, tie-break, quantum, back-to-back.
module tb_cnt_burst_arbiter;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Req0_valid = 1'b0, Req1_valid = 1'b0;
    logic [7:0] Req0_len = '0, Req1_len = '0;
    logic       Req0_ready, Req1_ready, Slt, En, Done0, Done1, Busy;

    int checks = 0;
    int errors = 0;
    int c0 = 0, c1 = 0, nd0 = 0, nd1 = 0;
    int base, viol = 0;
    logic prev_en = 1'b0, prev_slt = 1'b0;

    // {En,Slt} and {Done0,Done1} per cycle for the tie-break burst pair
    logic [1:0] tie_es [7] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b11, 2'b01};
    logic [1:0] tie_dd [7] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
    int         q_len  [5] = '{16, 16, 16, 4, 8};
    logic       q_ch   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    cnt_burst_arbiter #(.LEN_W(8), .QUANTUM(16)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req0_valid(Req0_valid), .Req0_len(Req0_len), .Req0_ready(Req0_ready),
        .Req1_valid(Req1_valid), .Req1_len(Req1_len), .Req1_ready(Req1_ready),
        .Slt(Slt), .En(En), .Done0(Done0), .Done1(Done1), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (En && !Slt) c0 <= c0 + 1;
        if (En && Slt) c1 <= c1 + 1;
        if (Done0) nd0 <= nd0 + 1;
        if (Done1) nd1 <= nd1 + 1;
        if (prev_en && En && (prev_slt != Slt)) viol <= viol + 1;
        prev_en  <= En;
        prev_slt <= Slt;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        chk("reset_outs", {Slt, En, Done0, Done1, Busy, Req0_ready, Req1_ready}, 7'b0000011);
        Reset = 1'b0;
        tick();

        // reset in the middle of a ch0 burst
        Req0_valid = 1'b1; Req0_len = 8'd10;
        tick();
        Req0_valid = 1'b0;
        chk("a_ready0_low", Req0_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("a_en", {En, Slt}, 2'b10);
        end
        base = nd0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("a_after_reset", {Slt, En, Done0, Busy, Req0_ready, Req1_ready}, 6'b000011);
        for (int i = 0; i < 12; i++) tick();
        chk("a_no_done0", nd0 - base, 0);
        chk("a_idle_en", {En, Busy}, 2'b00);

        // single ch0 burst of 5
        base = c0;
        Req0_valid = 1'b1; Req0_len = 8'd5;
        tick();
        Req0_valid = 1'b0;
        chk("b_first_dead", En, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("b_en", {En, Slt, Done0}, 3'b100);
        end
        tick();
        chk("b_done", {En, Done0, Req0_ready}, 3'b011);
        tick();
        chk("b_done_pulse", {Done0, Busy}, 2'b00);
        chk("b_count", c0 - base, 5);

        // zero-length ch1 request
        Req1_valid = 1'b1; Req1_len = 8'd0;
        tick();
        Req1_valid = 1'b0;
        chk("c_accept", {En, Done1, Req1_ready}, 3'b001);
        tick();
        chk("c_done1", {En, Done1, Req1_ready, Slt}, 4'b0110);
        tick();
        chk("c_done1_end", {Done1, Busy}, 2'b00);

        // simultaneous accept after reset: ch0 wins the tie
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        Req0_valid = 1'b1; Req0_len = 8'd3;
        Req1_valid = 1'b1; Req1_len = 8'd2;
        tick();
        Req0_valid = 1'b0; Req1_valid = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("d_en_slt", {En, Slt}, tie_es[i]);
            chk("d_done", {Done0, Done1}, tie_dd[i]);
        end

        // quantum split of two long bursts
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        Req0_valid = 1'b1; Req0_len = 8'd40;
        Req1_valid = 1'b1; Req1_len = 8'd20;
        tick();
        Req0_valid = 1'b0; Req1_valid = 1'b0;
        for (int s = 0; s < 5; s++) begin
            if (s > 0) begin
                tick();
                chk("e_gap", {En, Slt, Busy}, {1'b0, q_ch[s], 1'b1});
                chk("e_gap_done1", Done1, (s == 4) ? 1'b1 : 1'b0);
            end
            for (int j = 0; j < q_len[s]; j++) begin
                tick();
                chk("e_run", {En, Slt}, {1'b1, q_ch[s]});
            end
        end
        tick();
        chk("e_end", {En, Done0, Done1}, 3'b010);
        tick();
        chk("e_idle", Busy, 1'b0);

        // back-to-back ch0 bursts, second issued as ready rises
        base = nd0;
        Req0_valid = 1'b1; Req0_len = 8'd3;
        tick();
        Req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("f_en1", {En, Slt}, 2'b10);
        end
        chk("f_ready_rise", Req0_ready, 1'b1);
        Req0_valid = 1'b1; Req0_len = 8'd3;
        tick();
        Req0_valid = 1'b0;
        chk("f_gap", {En, Done0}, 2'b01);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("f_en2", {En, Slt, Done0}, 3'b100);
        end
        tick();
        chk("f_end", {En, Done0}, 2'b01);
        tick();
        chk("f_done_count", nd0 - base, 2);
        chk("no_b2b_owner_change", viol, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
